// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions for the transmit and receive paths.
// - ns_to_cycles: converts a line-timing figure in ns to clock cycles.
// - default timing localparams (T0H/T1H/bit period/latch) at 20 MHz.
// - pixel byte-order helpers between wire order and the packed pixel word.
// - receiver state enum.
package ws2812_pkg;

  localparam int unsigned DefClkFreq = 20_000_000;

  // The clock is reduced to whole MHz first so the product cannot overflow 32 bits.
  function automatic int unsigned ns_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ns);
    return ((clk_freq / 1_000_000) * ns) / 1000;
  endfunction

  localparam int unsigned T0hCycles   = ns_to_cycles(DefClkFreq, 400);
  localparam int unsigned T1hCycles   = ns_to_cycles(DefClkFreq, 800);
  localparam int unsigned BitCycles   = ns_to_cycles(DefClkFreq, 1250);
  localparam int unsigned LatchCycles = ns_to_cycles(DefClkFreq, 50_000);

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StHigh,
    StLow
  } rx_state_e;

  // Wire order is {first, second, third} byte; the packed word keeps the
  // second byte on top, the first in the middle and the third at the bottom.
  function automatic logic [23:0] wire_to_word(input logic [23:0] w);
    return {w[15:8], w[23:16], w[7:0]};
  endfunction

  function automatic logic [23:0] word_to_wire(input logic [23:0] p);
    return {p[15:8], p[23:16], p[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Line front end for the WS2812 receiver: 2-flop synchronizer, edge detect
// and saturating high/low run-length counters.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   din           - asynchronous serial line
//   keep_lo       - 0: any high sample clears the low counter (idle hunting)
//                   1: glitch highs leave the low counter running
//   rise          - synchronized line just went high
//   pulse_done    - synchronized line just went low; width is valid
//   width         - length in cycles of the high pulse that just ended
//   low_timeout   - line has been low for LATCH_CYCLES cycles (one-cycle strobe)
module ws2812_pulse_meas #(
  parameter int unsigned MIN_HIGH     = 3,
  parameter int unsigned LATCH_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        din,
  input  logic        keep_lo,
  output logic        rise,
  output logic        pulse_done,
  output logic [10:0] width,
  output logic        low_timeout
);

  localparam logic [10:0] CntMax   = '1;
  localparam logic [10:0] MinHigh  = 11'(MIN_HIGH);
  localparam logic [10:0] LatchCnt = 11'(LATCH_CYCLES);

  logic        s1_q, s2_q, s3_q;
  logic [10:0] hi_q, hi_d;
  logic [10:0] lo_q, lo_d;
  logic        fall;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CntMax) ? v : v + 11'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;

    hi_d = hi_q;
    if (s2_q) begin
      hi_d = s3_q ? sat_inc(hi_q) : 11'd1;
    end

    // A glitch falling edge keeps the low run going; a real pulse restarts it.
    if (s2_q) begin
      lo_d = keep_lo ? lo_q : '0;
    end else if (fall && (hi_q >= MinHigh)) begin
      lo_d = 11'd1;
    end else begin
      lo_d = sat_inc(lo_q);
    end
  end

  assign pulse_done  = fall;
  assign width       = hi_q;
  assign low_timeout = ~s2_q && (lo_q == LatchCnt);

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: classifies high pulses into bits, assembles 24-bit
// pixels in receive order and flags the frame boundary on the latch gap.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   din           - asynchronous serial line
//   pix_valid     - one-cycle strobe, pix_data/pix_index valid
//   pix_data      - packed pixel word (wire_to_word of the three wire bytes)
//   pix_index     - 0-based pixel position in the frame
//   frame_done    - one-cycle strobe on the latch gap
//   pix_count     - pixels delivered in the frame just ended
//   err           - sticky error (over-long high, partial pixel, overflow)
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DefClkFreq,
  parameter int unsigned NUM_LEDS     = 256,
  parameter int unsigned BIT_THRESH   = ns_to_cycles(CLK_FREQ, 600),
  parameter int unsigned MIN_HIGH     = ns_to_cycles(CLK_FREQ, 150),
  parameter int unsigned MAX_HIGH     = ns_to_cycles(CLK_FREQ, 1500),
  parameter int unsigned LATCH_CYCLES = ns_to_cycles(CLK_FREQ, 50_000)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        din,
  output logic                        pix_valid,
  output logic [23:0]                 pix_data,
  output logic [$clog2(NUM_LEDS):0]   pix_index,
  output logic                        frame_done,
  output logic [$clog2(NUM_LEDS):0]   pix_count,
  output logic                        err
);

  localparam int unsigned IdxW      = $clog2(NUM_LEDS) + 1;
  localparam logic [10:0] MinHigh   = 11'(MIN_HIGH);
  localparam logic [10:0] MaxHigh   = 11'(MAX_HIGH);
  localparam logic [10:0] BitThresh = 11'(BIT_THRESH);
  localparam logic [IdxW-1:0] PixMax = IdxW'(NUM_LEDS);

  logic        rise, pulse_done, low_timeout;
  logic [10:0] width;

  rx_state_e       state_q, state_d;
  logic            from_low_q, from_low_d;
  logic [23:0]     sr_q, sr_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [IdxW-1:0] pix_cnt_q, pix_cnt_d;
  logic            pix_valid_q, pix_valid_d;
  logic [23:0]     pix_data_q, pix_data_d;
  logic [IdxW-1:0] pix_index_q, pix_index_d;
  logic            frame_done_q, frame_done_d;
  logic [IdxW-1:0] pix_count_q, pix_count_d;
  logic            err_q, err_d;

  ws2812_pulse_meas #(
    .MIN_HIGH     (MIN_HIGH),
    .LATCH_CYCLES (LATCH_CYCLES)
  ) u_meas (
    .clock       (clock),
    .reset       (reset),
    .din         (din),
    .keep_lo     (state_q != StWaitIdle),
    .rise        (rise),
    .pulse_done  (pulse_done),
    .width       (width),
    .low_timeout (low_timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StWaitIdle;
      from_low_q   <= 1'b0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_index_q  <= '0;
      frame_done_q <= 1'b0;
      pix_count_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      from_low_q   <= from_low_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_index_q  <= pix_index_d;
      frame_done_q <= frame_done_d;
      pix_count_q  <= pix_count_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    from_low_d   = from_low_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    pix_valid_d  = 1'b0;
    pix_data_d   = pix_data_q;
    pix_index_d  = pix_index_q;
    frame_done_d = 1'b0;
    pix_count_d  = pix_count_q;
    err_d        = err_q;

    // Pixel completion runs the cycle after the 24th bit lands; no other bit
    // event can occur in that cycle since a new rise must come first.
    if (bit_cnt_q == 5'd24) begin
      bit_cnt_d = '0;
      if (pix_cnt_q == PixMax) begin
        err_d = 1'b1;
      end else begin
        pix_valid_d = 1'b1;
        pix_data_d  = wire_to_word(sr_q);
        pix_index_d = pix_cnt_q;
        pix_cnt_d   = pix_cnt_q + IdxW'(1);
      end
    end

    case (state_q)
      StWaitIdle: begin
        if (low_timeout) begin
          state_d   = StIdle;
          pix_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      StIdle: begin
        if (rise) begin
          state_d    = StHigh;
          from_low_d = 1'b0;
        end
      end
      StHigh: begin
        if (pulse_done) begin
          if (width < MinHigh) begin
            state_d = from_low_q ? StLow : StIdle;
          end else if (width > MaxHigh) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
            state_d   = StWaitIdle;
          end else begin
            sr_d      = {sr_q[22:0], width >= BitThresh};
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = StLow;
          end
        end
      end
      StLow: begin
        if (rise) begin
          state_d    = StHigh;
          from_low_d = 1'b1;
        end else if (low_timeout) begin
          frame_done_d = 1'b1;
          pix_count_d  = pix_cnt_q;
          pix_cnt_d    = '0;
          bit_cnt_d    = '0;
          if (bit_cnt_q != 5'd0) begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_index  = pix_index_q;
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx at 20 MHz with a 16-pixel frame so the
// overflow case stays short. Expected words come from the wire bytes.
module tb_ws2812_rx;

  localparam int unsigned NLeds = 16;
  localparam int T0h = 8;
  localparam int T1h = 16;
  localparam int TBit = 25;
  localparam int Gap = 1100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [4:0]  pix_index;
  logic        frame_done;
  logic [4:0]  pix_count;
  logic        err;

  int total = 0;
  int bad = 0;
  int both = 0;

  logic [23:0] got_data[$];
  int          got_idx[$];
  int          got_cnt[$];
  logic [23:0] exp_q[$];
  logic [23:0] w;
  logic [23:0] frame[5];

  always #5 clock = ~clock;

  ws2812_rx #(
    .NUM_LEDS (NLeds)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_index  (pix_index),
    .frame_done (frame_done),
    .pix_count  (pix_count),
    .err        (err)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (pix_valid) begin
        got_data.push_back(pix_data);
        got_idx.push_back(int'(pix_index));
      end
      if (frame_done) got_cnt.push_back(int'(pix_count));
      if (pix_valid && frame_done) both++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed word: second wire byte on top, first in the middle, third at the bottom.
  function automatic logic [23:0] pack(input logic [23:0] wire_bytes);
    logic [7:0] first, second, third;
    first  = wire_bytes[23:16];
    second = wire_bytes[15:8];
    third  = wire_bytes[7:0];
    return {second, first, third};
  endfunction

  task automatic hold(input logic level, input int n);
    din = level;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, b ? T1h : T0h);
    hold(1'b0, TBit - (b ? T1h : T0h));
  endtask

  task automatic send_pixel(input logic [23:0] px);
    for (int i = 23; i >= 0; i--) send_bit(px[i]);
  endtask

  task automatic clear();
    got_data.delete();
    got_idx.delete();
    got_cnt.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold(1'b0, 3);
    reset = 1'b0;
  endtask

  task automatic verify(input string tag);
    int n;
    chk({tag, "_npix"}, got_data.size(), exp_q.size());
    n = (got_data.size() < exp_q.size()) ? got_data.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_q[i]);
      chk($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
    end
  endtask

  task automatic verify_frames(input string tag, input int n_frames, input int cnt);
    chk({tag, "_nframe"}, got_cnt.size(), n_frames);
    if (got_cnt.size() > 0 && n_frames > 0) chk({tag, "_count"}, got_cnt[0], cnt);
  endtask

  initial begin
    // Reset state
    hold(1'b0, 5);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_index", pix_index, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    // 1: single known pixel
    hold(1'b0, Gap);
    clear();
    exp_q.push_back(24'h341256);
    send_pixel(24'h123456);
    hold(1'b0, Gap);
    verify("t1");
    verify_frames("t1", 1, 1);
    chk("t1_err", err, 0);

    // 2: full random frame
    clear();
    for (int i = 0; i < NLeds; i++) begin
      w = 24'($urandom);
      exp_q.push_back(pack(w));
      send_pixel(w);
    end
    hold(1'b0, Gap);
    verify("t2");
    verify_frames("t2", 1, NLeds);
    chk("t2_err", err, 0);

    // 3: 2-cycle glitch in the low phase of bit 5
    clear();
    w = 24'($urandom);
    exp_q.push_back(pack(w));
    for (int i = 23; i >= 0; i--) begin
      if (i == 18) begin
        hold(1'b1, w[i] ? T1h : T0h);
        hold(1'b0, 3);
        hold(1'b1, 2);
        hold(1'b0, TBit - (w[i] ? T1h : T0h) - 5);
      end else begin
        send_bit(w[i]);
      end
    end
    hold(1'b0, Gap);
    verify("t3");
    verify_frames("t3", 1, 1);
    chk("t3_err", err, 0);

    // 4: over-long high mid-pixel, then recovery
    clear();
    w = 24'($urandom);
    for (int i = 23; i >= 14; i--) send_bit(w[i]);
    hold(1'b1, 40);
    hold(1'b0, Gap);
    chk("t4_nopix", got_data.size(), 0);
    chk("t4_err", err, 1);
    w = 24'($urandom);
    exp_q.push_back(pack(w));
    send_pixel(w);
    hold(1'b0, Gap);
    verify("t4");
    verify_frames("t4", 1, 1);

    // 5a: 30 bits then latch
    do_reset();
    chk("t5a_err_cleared", err, 0);
    hold(1'b0, Gap);
    clear();
    w = 24'($urandom);
    exp_q.push_back(pack(w));
    send_pixel(w);
    w = 24'($urandom);
    for (int i = 23; i >= 18; i--) send_bit(w[i]);
    hold(1'b0, Gap);
    verify("t5a");
    verify_frames("t5a", 1, 1);
    chk("t5a_err", err, 1);

    // 5b: one pixel more than the frame holds
    do_reset();
    hold(1'b0, Gap);
    clear();
    for (int i = 0; i <= NLeds; i++) begin
      w = 24'($urandom);
      if (i < NLeds) exp_q.push_back(pack(w));
      send_pixel(w);
    end
    hold(1'b0, Gap);
    verify("t5b");
    verify_frames("t5b", 1, NLeds);
    chk("t5b_err", err, 1);

    // 6: reset at bit 100, stream continues
    do_reset();
    hold(1'b0, Gap);
    for (int p = 0; p < 5; p++) frame[p] = 24'($urandom);
    for (int k = 0; k < 100; k++) send_bit(frame[k / 24][23 - (k % 24)]);
    clear();
    reset = 1'b1;
    send_bit(frame[4][23 - 4]);
    reset = 1'b0;
    for (int k = 101; k < 120; k++) send_bit(frame[k / 24][23 - (k % 24)]);
    hold(1'b0, Gap);
    chk("t6_nopix", got_data.size(), 0);
    chk("t6_noframe", got_cnt.size(), 0);
    for (int i = 0; i < 2; i++) begin
      w = 24'($urandom);
      exp_q.push_back(pack(w));
      send_pixel(w);
    end
    hold(1'b0, Gap);
    verify("t6");
    verify_frames("t6", 1, 2);
    chk("t6_err", err, 0);

    chk("never_both_strobes", both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
